button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  - N-channel conditioner for asynchronous, un-debounced board inputs (icebreaker push-buttons).
//  - Per channel: multi-flop synchroniser, polarity normalisation, debounce counter,
//    one-cycle press/release pulses and a long-press hold flag.
//  - Sits directly behind the top-level pads; all downstream logic consumes its outputs.
//  - Generalises the fixed two-flop reset synchroniser to N channels, configurable depth and debounce.
// PARAMETERS
//  - NUM_CH         3        number of independent input channels
//  - SYNC_STAGES    2        synchroniser flops per channel, >= 2
//  - DEBOUNCE_CYCLES 120000  consecutive disagreeing cycles before level flips, >= 1 (10 ms @ 12 MHz)
//  - HOLD_CYCLES    0        cycles of stable press before hold_o asserts; 0 disables hold_o (tied 0)
//  - ACTIVE_LOW     '1       NUM_CH-bit mask; bit=1 means pad reads 0 when pressed
// PORTS
//  - clk_i       in   1       system clock (12 MHz)
//  - reset_n_i   in   1       asynchronous, active-low reset
//  - btn_async_i in   NUM_CH  raw pad inputs, asynchronous, bouncing
//  - level_o     out  NUM_CH  debounced level, 1 = pressed (polarity already normalised)
//  - press_o     out  NUM_CH  1-cycle pulse on 0->1 of level_o
//  - release_o   out  NUM_CH  1-cycle pulse on 1->0 of level_o
//  - hold_o      out  NUM_CH  1 while pressed for >= HOLD_CYCLES cycles
// BEHAVIOUR
//  - Reset (async assert, sync deassert by system): sync flops load inactive pad level
//    (ACTIVE_LOW[i] ? 1 : 0); level_o, press_o, release_o, hold_o = 0; all counters = 0.
//  - Synchroniser: SYNC_STAGES cascaded flops; output XOR ACTIVE_LOW[i] gives pressed_s[i].
//  - Debounce, per channel, each edge:
//      pressed_s == level  -> db_cnt <= 0
//      pressed_s != level, db_cnt <  DEBOUNCE_CYCLES-1 -> db_cnt++
//      pressed_s != level, db_cnt == DEBOUNCE_CYCLES-1 -> level <= ~level, db_cnt <= 0
//  - Any single agreeing cycle mid-count clears db_cnt (glitch rejection); no partial credit.
//  - DEBOUNCE_CYCLES=1: level follows pressed_s with one extra cycle, no filtering.
//  - Latency: pad change held steady -> level_o flips exactly SYNC_STAGES+DEBOUNCE_CYCLES
//    rising edges later.
//  - press_o/release_o are registered; asserted in the same cycle as the first cycle
//    of the new level_o value, for exactly one cycle. Never both high on one channel.
//  - Hold: hold_cnt counts cycles with level_o=1, saturating at HOLD_CYCLES; hold_o=1 when
//    hold_cnt==HOLD_CYCLES; hold_cnt and hold_o clear in the cycle level_o falls.
//    hold_o first asserts HOLD_CYCLES cycles after press_o.
//  - Channels fully independent; simultaneous events on several channels are all reported
//    in the same cycle.
//  - Counter widths: $clog2(DEBOUNCE_CYCLES+1), $clog2(HOLD_CYCLES+1), min 1 bit; no wrap
//    possible (saturate / clear).
//  - Reset asserted mid-debounce or mid-hold: state discarded; after release, a pad already
//    pressed needs the full SYNC_STAGES+DEBOUNCE_CYCLES before press_o fires.
// STRUCTURE
//  - Shared package button_pkg: width helper function cnt_width(n), default debounce constant
//    DEBOUNCE_10MS_12MHZ = 120000.
//  - Sub-module button_channel (one channel: sync chain, debounce, edge, hold), instantiated
//    NUM_CH times in a generate loop; top level only does polarity mask slicing and wiring.
//  - No combinational path from btn_async_i to any output.
// TESTING
//  - Bench params: NUM_CH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10,
//    ACTIVE_LOW=3'b011.
//  - Reset: reset_n_i=0 with pads=3'b011 (all idle) -> all outputs 0; release, 20 cycles
//    idle -> outputs stay 0.
//  - Clean press: ch0 pad 1->0 held -> level_o[0]=1 and press_o[0]=1 exactly 6 edges later,
//    press_o[0] low next cycle.
//  - Bounce: ch1 pad toggles active 3 cycles / idle 1 cycle, repeated 5 times -> no press_o[1],
//    level_o[1] stays 0.
//  - Hold and release: ch2 (active-high) driven 1 for 30 cycles then 0 -> hold_o[2] rises
//    10 cycles after press_o[2]; on release, release_o[2] pulses once, and hold_o[2] clears
//    in the same cycle as level_o[2].
//  - Simultaneous: ch0 and ch2 pressed same cycle -> press_o=3'b101 in a single cycle.
//  - Reset mid-operation: assert reset_n_i 2 cycles into ch0 debounce, release with pad still
//    pressed -> press_o[0] fires 6 edges after release, not earlier.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioner.
// cnt_width() sizes a counter that must hold 0..n inclusive, never narrower than one bit.
package button_pkg;

   localparam int DEBOUNCE_10MS_12MHZ = 120000;

   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pad-side input and conditioned outputs of the button conditioner, one bit per channel.
// The conditioner is the slave; the consuming logic (or a bench) is the master.
interface button_conditioner_if #(
   parameter int NUM_CH = 3
);
   logic [NUM_CH-1:0] btn_async_i;
   logic [NUM_CH-1:0] level_o;
   logic [NUM_CH-1:0] press_o;
   logic [NUM_CH-1:0] release_o;
   logic [NUM_CH-1:0] hold_o;

   modport master (
      output btn_async_i,
      input  level_o,
      input  press_o,
      input  release_o,
      input  hold_o
   );

   modport slave (
      input  btn_async_i,
      output level_o,
      output press_o,
      output release_o,
      output hold_o
   );
endinterface

// File: rtl/button_channel.sv
// One button channel: synchroniser chain, polarity fix, debounce counter,
// registered press/release pulses and an optional saturating long-press flag.
module button_channel
   import button_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
   parameter int   HOLD_CYCLES     = 0,
   parameter logic ACTIVE_LOW      = 1'b1
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic btn_async_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DW-1:0]          db_cnt_q, db_cnt_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   pressed_s;
   logic                   flip;

   // A single agreeing cycle drops the count back to zero: no partial credit.
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], btn_async_i};
      pressed_s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
      flip      = 1'b0;
      db_cnt_d  = '0;
      if (pressed_s != level_q) begin
         if (db_cnt_q == DB_MAX) flip = 1'b1;
         else                    db_cnt_d = db_cnt_q + DW'(1);
      end
      level_d   = level_q ^ flip;
      press_d   = flip & ~level_q;
      release_d = flip & level_q;
   end

   // Sync flops come out of reset holding the idle pad level so nothing fires spuriously.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync_q    <= {SYNC_STAGES{ACTIVE_LOW}};
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

   generate
      if (HOLD_CYCLES == 0) begin : g_no_hold
         assign hold_o = 1'b0;
      end else begin : g_hold
         localparam int HW = cnt_width(HOLD_CYCLES);
         localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

         logic [HW-1:0] hold_cnt_q, hold_cnt_d;

         // Counting starts the cycle after press_o, so hold_o rises HOLD_CYCLES after it.
         always_comb begin
            hold_cnt_d = hold_cnt_q;
            if (!level_d)
               hold_cnt_d = '0;
            else if (level_q && (hold_cnt_q != HOLD_MAX))
               hold_cnt_d = hold_cnt_q + HW'(1);
         end

         always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) hold_cnt_q <= '0;
            else            hold_cnt_q <= hold_cnt_d;
         end

         assign hold_o = (hold_cnt_q == HOLD_MAX);
      end
   endgenerate

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button conditioner: slices the polarity mask and replicates
// one independent button_channel per pad.
module button_conditioner
   import button_pkg::*;
#(
   parameter int              NUM_CH          = 3,
   parameter int              SYNC_STAGES     = 2,
   parameter int              DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
   parameter int              HOLD_CYCLES     = 0,
   parameter logic [NUM_CH-1:0] ACTIVE_LOW    = '1
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   button_conditioner_if.slave  bus
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      button_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW[i])
      ) u_ch (
         .clk_i       (clk_i),
         .reset_n_i   (reset_n_i),
         .btn_async_i (bus.btn_async_i[i]),
         .level_o     (bus.level_o[i]),
         .press_o     (bus.press_o[i]),
         .release_o   (bus.release_o[i]),
         .hold_o      (bus.hold_o[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: reset, clean press, bounce rejection,
// hold/release, simultaneous presses and reset during debounce.
module tb_button_conditioner;

   logic clk_i;
   logic reset_n_i;
   int   tests;
   int   fails;

   button_conditioner_if #(.NUM_CH(3)) bus ();

   button_conditioner #(
      .NUM_CH          (3),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .ACTIVE_LOW      (3'b011)
   ) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .bus       (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Inputs change and outputs are sampled on the falling edge, away from the active edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset_n_i = 1'b0;
      bus.btn_async_i = 3'b011;

      // Reset with all pads idle
      step(3);
      check("rst_level",   bus.level_o,   3'b000);
      check("rst_press",   bus.press_o,   3'b000);
      check("rst_release", bus.release_o, 3'b000);
      check("rst_hold",    bus.hold_o,    3'b000);
      reset_n_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("idle_level", bus.level_o, 3'b000);
         check("idle_press", bus.press_o, 3'b000);
      end

      // Clean press on ch0 (active low)
      bus.btn_async_i = 3'b010;
      step(5);
      check("ch0_level_early", bus.level_o, 3'b000);
      check("ch0_press_early", bus.press_o, 3'b000);
      step(1);
      check("ch0_level", bus.level_o, 3'b001);
      check("ch0_press", bus.press_o, 3'b001);
      step(1);
      check("ch0_press_1cyc", bus.press_o, 3'b000);
      check("ch0_level_held", bus.level_o, 3'b001);
      bus.btn_async_i = 3'b011;
      step(5);
      check("ch0_rel_early", bus.release_o, 3'b000);
      step(1);
      check("ch0_rel",       bus.release_o, 3'b001);
      check("ch0_rel_level", bus.level_o,   3'b000);
      check("ch0_rel_hold",  bus.hold_o,    3'b000);
      step(1);
      check("ch0_rel_1cyc",  bus.release_o, 3'b000);

      // Bouncing ch1: 3 cycles active, 1 idle, five times
      for (int r = 0; r < 5; r++) begin
         bus.btn_async_i = 3'b001;
         for (int k = 0; k < 3; k++) begin
            step(1);
            check("bounce_level", bus.level_o, 3'b000);
            check("bounce_press", bus.press_o, 3'b000);
         end
         bus.btn_async_i = 3'b011;
         step(1);
         check("bounce_level", bus.level_o, 3'b000);
         check("bounce_press", bus.press_o, 3'b000);
      end
      for (int k = 0; k < 8; k++) begin
         step(1);
         check("bounce_tail_level", bus.level_o, 3'b000);
         check("bounce_tail_press", bus.press_o, 3'b000);
      end

      // Hold and release on ch2 (active high), pressed for 30 cycles
      bus.btn_async_i = 3'b111;
      step(6);
      check("ch2_press", bus.press_o, 3'b100);
      check("ch2_level", bus.level_o, 3'b100);
      check("ch2_hold0", bus.hold_o,  3'b000);
      for (int k = 1; k < 10; k++) begin
         step(1);
         check("ch2_hold_early", bus.hold_o, 3'b000);
      end
      step(1);
      check("ch2_hold_rise", bus.hold_o, 3'b100);
      step(14);
      check("ch2_hold_sat", bus.hold_o, 3'b100);
      bus.btn_async_i = 3'b011;
      step(5);
      check("ch2_rel_early_lvl",  bus.level_o,   3'b100);
      check("ch2_rel_early_hold", bus.hold_o,    3'b100);
      check("ch2_rel_early_rel",  bus.release_o, 3'b000);
      step(1);
      check("ch2_rel_level", bus.level_o,   3'b000);
      check("ch2_rel_hold",  bus.hold_o,    3'b000);
      check("ch2_rel",       bus.release_o, 3'b100);
      check("ch2_rel_press", bus.press_o,   3'b000);
      step(1);
      check("ch2_rel_1cyc", bus.release_o, 3'b000);

      // Simultaneous press on ch0 and ch2
      bus.btn_async_i = 3'b110;
      step(5);
      check("sim_press_early", bus.press_o, 3'b000);
      step(1);
      check("sim_press", bus.press_o, 3'b101);
      check("sim_level", bus.level_o, 3'b101);
      step(1);
      check("sim_press_1cyc", bus.press_o, 3'b000);
      bus.btn_async_i = 3'b011;
      step(8);
      check("sim_released", bus.level_o, 3'b000);

      // Reset two cycles into ch0 debounce
      bus.btn_async_i = 3'b010;
      step(4);
      check("mid_level", bus.level_o, 3'b000);
      reset_n_i = 1'b0;
      step(2);
      check("mid_rst_level", bus.level_o, 3'b000);
      check("mid_rst_press", bus.press_o, 3'b000);
      reset_n_i = 1'b1;
      for (int k = 1; k < 6; k++) begin
         step(1);
         check("post_rst_press_early", bus.press_o, 3'b000);
      end
      step(1);
      check("post_rst_press", bus.press_o, 3'b001);
      check("post_rst_level", bus.level_o, 3'b001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
